// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - Board geometry, tile and painter state types shared by the PPU and the board painter.
package ppu_pkg;

  localparam int BOARD_WIDTH  = 342;
  localparam int BOARD_HEIGHT = 342;
  localparam int GRID_N       = 10;
  localparam int CELL_PITCH   = 34;
  localparam int CELL_ORIGIN  = 2;
  localparam int TILE_SIZE    = 32;

  typedef enum logic [1:0] {
    TILE_WATER = 2'd0,
    TILE_SHIP  = 2'd1,
    TILE_HIT   = 2'd2,
    TILE_MISS  = 2'd3
  } tile_e;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    COPY,
    FLUSH
  } painter_state_e;

  typedef logic [15:0] rgb565_t;

  // Pixel x (or y) of the top-left corner of cell column (or row) idx.
  function automatic logic [8:0] cell_origin(input logic [3:0] idx);
    return 9'(CELL_ORIGIN) + 9'(idx) * 9'(CELL_PITCH);
  endfunction

endpackage

// File: rtl/board_addr_gen.sv
// rtl/board_addr_gen.sv - Raster walk over one tile: tile-ROM offset plus matching board-RAM address.
module board_addr_gen
  import ppu_pkg::*;
(
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        advance,
  input  logic [8:0]  x0,
  input  logic [8:0]  y0,
  output logic [9:0]  tile_off,
  output logic [16:0] board_addr,
  output logic        last
);

  localparam logic [16:0] ORIGIN_BASE = 17'(BOARD_WIDTH * CELL_ORIGIN);
  localparam logic [4:0]  PX_MAX      = 5'(TILE_SIZE - 1);

  logic [4:0]  px;
  logic [4:0]  py;
  logic [8:0]  x_base;
  logic [16:0] row_base;
  logic [16:0] origin_base;
  logic [16:0] next_row_base;

  // Only multiply in the block: done once per cell, the rest is stride addition.
  assign origin_base   = 17'(BOARD_WIDTH) * {8'd0, y0};
  assign next_row_base = row_base + 17'(BOARD_WIDTH);

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      px         <= '0;
      py         <= '0;
      x_base     <= 9'(CELL_ORIGIN);
      row_base   <= ORIGIN_BASE;
      board_addr <= ORIGIN_BASE + 17'(CELL_ORIGIN);
    end else if (start) begin
      px         <= '0;
      py         <= '0;
      x_base     <= x0;
      row_base   <= origin_base;
      board_addr <= origin_base + {8'd0, x0};
    end else if (advance) begin
      if (px == PX_MAX) begin
        px         <= '0;
        py         <= py + 5'd1;
        row_base   <= next_row_base;
        board_addr <= next_row_base + {8'd0, x_base};
      end else begin
        px         <= px + 5'd1;
        board_addr <= board_addr + 17'd1;
      end
    end
  end

  assign tile_off = {py, px};
  assign last     = (px == PX_MAX) && (py == PX_MAX);

endmodule

// File: rtl/board_painter.sv
// rtl/board_painter.sv - Stamps a 32x32 RGB565 tile from the tile ROM into a Battleship board cell.
// Optional BOARD_PAINTER_INIT_EN: after reset paint every cell with water before taking commands.
module board_painter
  import ppu_pkg::*;
(
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_row,
  input  logic [3:0]  cmd_col,
  input  logic [1:0]  cmd_tile,
  output logic [11:0] tile_addr,
  input  logic [15:0] tile_q,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  painter_state_e state;
  painter_state_e state_next;
  tile_e          cur_tile;
  logic           accept;
  logic           cmd_legal;
  logic           streaming;
  logic           init_finish;
  logic           gen_start;
  logic           gen_last;
  logic [8:0]     gen_x0;
  logic [8:0]     gen_y0;
  logic [9:0]     tile_off;
  logic [16:0]    board_addr;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_legal = (cmd_row < 4'(GRID_N)) && (cmd_col < 4'(GRID_N));

`ifdef BOARD_PAINTER_INIT_EN
  localparam painter_state_e RESET_STATE = INIT;

  logic [3:0] init_row;
  logic [3:0] init_col;
  logic [3:0] init_row_nx;
  logic [3:0] init_col_nx;

  assign init_finish = gen_last && (init_row == 4'(GRID_N - 1)) && (init_col == 4'(GRID_N - 1));

  always_comb begin
    init_row_nx = init_row;
    init_col_nx = init_col + 4'd1;
    if (init_col == 4'(GRID_N - 1)) begin
      init_col_nx = '0;
      init_row_nx = init_row + 4'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      init_row <= '0;
      init_col <= '0;
    end else if ((state == INIT) && gen_last) begin
      init_row <= init_row_nx;
      init_col <= init_col_nx;
    end
  end

  // The next cell is loaded on the last pixel of the current one, so cells run back-to-back.
  assign gen_x0    = (state == INIT) ? cell_origin(init_col_nx) : cell_origin(cmd_col);
  assign gen_y0    = (state == INIT) ? cell_origin(init_row_nx) : cell_origin(cmd_row);
  assign gen_start = (accept && cmd_legal) || ((state == INIT) && gen_last && !init_finish);
`else
  localparam painter_state_e RESET_STATE = IDLE;

  assign init_finish = 1'b1;
  assign gen_x0      = cell_origin(cmd_col);
  assign gen_y0      = cell_origin(cmd_row);
  assign gen_start   = accept && cmd_legal;
`endif

  always_ff @(posedge vga_clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && cmd_legal) state_next = COPY;
      INIT:    if (init_finish) state_next = FLUSH;
      COPY:    if (gen_last) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    streaming = 1'b0;
    unique case (state)
      IDLE:        cmd_ready = 1'b1;
      INIT, COPY: begin
        busy      = 1'b1;
        streaming = 1'b1;
      end
      FLUSH:       busy = 1'b1;
      default:     ;
    endcase
  end

  board_addr_gen u_addr_gen (
    .vga_clk    (vga_clk),
    .rst        (rst),
    .start      (gen_start),
    .advance    (streaming),
    .x0         (gen_x0),
    .y0         (gen_y0),
    .tile_off   (tile_off),
    .board_addr (board_addr),
    .last       (gen_last)
  );

  assign tile_addr = streaming ? {cur_tile, tile_off} : '0;

  // Write stage lines up with the one-cycle ROM latency; tile_q already belongs to the registered address.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      cur_tile <= TILE_WATER;
    end else begin
      wr_en <= streaming;
      if (streaming) wr_addr <= board_addr;
      done  <= (state == FLUSH);
      err   <= accept && !cmd_legal;
      if (accept) cur_tile <= tile_e'(cmd_tile);
    end
  end

  assign wr_data = wr_en ? tile_q : '0;

endmodule

// File: tb/tb_board_painter.sv
// tb/tb_board_painter.sv - Self-checking bench for board_painter: vector table, random commands, corner sequences.
module tb_board_painter;

  logic        vga_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_row = '0;
  logic [3:0]  cmd_col = '0;
  logic [1:0]  cmd_tile = '0;
  logic [11:0] tile_addr;
  logic [15:0] tile_q;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  board_painter dut (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_tile  (cmd_tile),
    .tile_addr (tile_addr),
    .tile_q    (tile_q),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 vga_clk = ~vga_clk;

  logic [15:0] rom [4096];
  always @(posedge vga_clk) tile_q <= rom[tile_addr];

  typedef struct { int addr; int data; int ta; int cyc; } wr_rec_t;
  typedef struct { int r; int c; int t; int acc; } cmd_t;
  typedef struct { logic [3:0] r; logic [3:0] c; logic [1:0] t; int first; int last; } vec_t;

  wr_rec_t wq[$];
  int      dq[$];
  int      ncyc = 0;
  int      err_cnt = 0, err_cyc = -1, busy_cnt = 0, prev_ta = 0;
  int      bad_xy = 0, both_cnt = 0, idle_wr = 0;
  int      n_err = 0, n_chk = 0;

  always @(posedge vga_clk) ncyc <= ncyc + 1;

  always @(negedge vga_clk) begin
    if (!rst) begin
      if (wr_en) begin
        wq.push_back('{int'(wr_addr), int'(wr_data), prev_ta, ncyc});
        if ((int'(wr_addr) % 342) > 339 || (int'(wr_addr) / 342) > 339) bad_xy++;
        if (cmd_ready) idle_wr++;
      end
      if (done) dq.push_back(ncyc);
      if (err) begin err_cnt++; err_cyc = ncyc; end
      if (done && err) both_cnt++;
      if (busy) busy_cnt++;
    end
    prev_ta = int'(tile_addr);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge vga_clk);
    #1;
  endtask

  function automatic int exp_addr(input int r, input int c, input int i);
    return 342 * (2 + 34 * r + i / 32) + 2 + 34 * c + i % 32;
  endfunction

  task automatic clear_mon();
    wq.delete();
    dq.delete();
    err_cnt = 0;
    err_cyc = -1;
    busy_cnt = 0;
  endtask

  task automatic issue(input logic [3:0] r, input logic [3:0] c, input logic [1:0] t,
                       input bit hold, output int acc);
    cmd_row = r; cmd_col = c; cmd_tile = t; cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_ready) begin acc = ncyc; break; end
      tick();
    end
    chk("accept within bound", int'(acc >= 0), 1);
    if (acc < 0) begin cmd_valid = 1'b0; return; end
    @(posedge vga_clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 1200 * n && dq.size() < n; i++) tick();
    chk("done pulses", dq.size(), n);
  endtask

  task automatic check_writes(input string name, input cmd_t cl[$]);
    int bad = 0;
    int k = 0;
    chk({name, " write count"}, wq.size(), 1024 * cl.size());
    foreach (cl[j]) begin
      for (int i = 0; i < 1024; i++) begin
        if (k < wq.size()) begin
          if (wq[k].addr != exp_addr(cl[j].r, cl[j].c, i) ||
              wq[k].data != int'(rom[cl[j].t * 1024 + i]) ||
              wq[k].ta   != cl[j].t * 1024 + i ||
              wq[k].cyc  != cl[j].acc + 2 + i) bad++;
        end
        k++;
      end
    end
    chk({name, " pixel mismatches"}, bad, 0);
  endtask

  task automatic run_cmd(input string name, input logic [3:0] r, input logic [3:0] c,
                         input logic [1:0] t, input int first, input int last);
    bit   bad;
    int   a;
    cmd_t cl[$];
    bad = (r >= 4'd10) || (c >= 4'd10);
    clear_mon();
    issue(r, c, t, 1'b0, a);
    if (a < 0) return;
    if (bad) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk({name, " ready after reject"}, int'(cmd_ready), 1);
      end
      chk({name, " err pulses"}, err_cnt, 1);
      chk({name, " err cycle"}, err_cyc, a + 1);
      chk({name, " writes"}, wq.size(), 0);
      chk({name, " done pulses"}, dq.size(), 0);
    end else begin
      wait_done(1);
      if (dq.size() > 0) chk({name, " done cycle"}, dq[0], a + 1026);
      chk({name, " ready at done"}, int'(cmd_ready), 1);
      chk({name, " busy cycles"}, busy_cnt, 1025);
      chk({name, " err pulses"}, err_cnt, 0);
      cl.push_back('{int'(r), int'(c), int'(t), a});
      check_writes(name, cl);
      if (wq.size() > 0) begin
        chk({name, " first wr_addr"}, wq[0].addr, first);
        chk({name, " last wr_addr"}, wq[wq.size() - 1].addr, last);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name, input int exp_ready);
    chk({name, " cmd_ready"}, int'(cmd_ready), exp_ready);
    chk({name, " wr_en"}, int'(wr_en), 0);
    chk({name, " wr_addr"}, int'(wr_addr), 0);
    chk({name, " wr_data"}, int'(wr_data), 0);
    chk({name, " tile_addr"}, int'(tile_addr), 0);
    chk({name, " busy/done/err"}, int'({busy, done, err}), 0);
  endtask

`ifdef BOARD_PAINTER_INIT_EN
  logic [15:0] dut_ram [116964];
  logic [15:0] exp_ram [116964];
`endif

  vec_t vt[6];

  initial begin
    int a1;
    int a2;
    cmd_t cl[$];
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);

    vt[0] = '{4'd0,  4'd0,  2'd2, 686,    11319};
    vt[1] = '{4'd9,  4'd9,  2'd3, 105644, 116277};
    vt[2] = '{4'd10, 4'd3,  2'd1, 0,      0};
    vt[3] = '{4'd3,  4'd10, 2'd0, 0,      0};
    vt[4] = '{4'd4,  4'd7,  2'd0, 47436,  58069};
    vt[5] = '{4'd15, 4'd15, 2'd2, 0,      0};

    rst = 1'b1;
    repeat (3) tick();
`ifdef BOARD_PAINTER_INIT_EN
    check_reset_outputs("reset", 0);
    clear_mon();
    rst = 1'b0;
    begin
      int ready_hi = 0;
      for (int i = 0; i < 104000 && dq.size() == 0; i++) begin
        tick();
        if (cmd_ready && dq.size() == 0) ready_hi++;
      end
      chk("init ready while painting", ready_hi, 0);
    end
    chk("init done pulses", dq.size(), 1);
    chk("init write count", wq.size(), 102400);
    for (int i = 0; i < 116964; i++) begin dut_ram[i] = '0; exp_ram[i] = '0; end
    foreach (wq[k]) dut_ram[wq[k].addr] = wq[k].data[15:0];
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        for (int i = 0; i < 1024; i++) exp_ram[exp_addr(r, c, i)] = rom[i];
    run_cmd("cmd 5,5 hit", 4'd5, 4'd5, 2'd2, exp_addr(5, 5, 0), exp_addr(5, 5, 1023));
    foreach (wq[k]) dut_ram[wq[k].addr] = wq[k].data[15:0];
    for (int i = 0; i < 1024; i++) exp_ram[exp_addr(5, 5, i)] = rom[2048 + i];
    begin
      int ram_bad = 0;
      for (int i = 0; i < 116964; i++) if (dut_ram[i] !== exp_ram[i]) ram_bad++;
      chk("board RAM contents", ram_bad, 0);
    end
`else
    check_reset_outputs("reset", 1);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++)
      run_cmd($sformatf("vec%0d", v), vt[v].r, vt[v].c, vt[v].t, vt[v].first, vt[v].last);

    for (int n = 0; n < 5; n++) begin
      logic [3:0] r;
      logic [3:0] c;
      logic [1:0] t;
      r = 4'($urandom_range(0, 11));
      c = 4'($urandom_range(0, 11));
      t = 2'($urandom_range(0, 3));
      run_cmd($sformatf("rand%0d", n), r, c, t, exp_addr(int'(r), int'(c), 0), exp_addr(int'(r), int'(c), 1023));
    end

    clear_mon();
    issue(4'd1, 4'd2, 2'd1, 1'b1, a1);
    issue(4'd7, 4'd8, 2'd3, 1'b0, a2);
    chk("b2b second accept cycle", a2, a1 + 1026);
    wait_done(2);
    if (dq.size() > 0) chk("b2b first done cycle", dq[0], a2);
    cl.push_back('{1, 2, 1, a1});
    cl.push_back('{7, 8, 3, a2});
    check_writes("b2b", cl);

    clear_mon();
    issue(4'd2, 4'd6, 2'd2, 1'b0, a1);
    for (int i = 0; i < 1100 && wq.size() < 500; i++) tick();
    chk("mid-copy writes before reset", wq.size(), 500);
    rst = 1'b1;
    tick();
    check_reset_outputs("mid-copy reset", 1);
    rst = 1'b0;
    tick();
    chk("aborted copy done pulses", dq.size(), 0);
    run_cmd("after reset 4,4 ship", 4'd4, 4'd4, 2'd1, exp_addr(4, 4, 0), exp_addr(4, 4, 1023));
`endif

    chk("writes outside board", bad_xy, 0);
    chk("done with err same cycle", both_cnt, 0);
    chk("writes while ready", idle_wr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
